sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO: the next generation of the team's 32-bit × 8 FIFO, generalised in data width and depth. It adds a fill-level count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow flags, a synchronous flush, and a compile-time first-word-fall-through read mode. It is used wherever producer and consumer share one clock, so no pointer synchronisers are needed.

---
 rtl/sync_fifo_param.sv | 111 +++++++++++
 tb/tb_sync_fifo_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, almost-full/empty thresholds,
// sticky overflow/underflow and synchronous flush. Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 1,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              w_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              r_en,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [PTR_W-1:0]  wptr_d, rptr_d, count_d;
    logic              overflow_d, underflow_d;
    logic              full_d, empty_d, almost_full_d, almost_empty_d;
    logic              wr_ok, rd_ok;

    // Acceptance uses the registered flags, so a same-cycle pop never frees a slot
    // and a same-cycle push never supplies data.
    assign wr_ok = w_en & ~full;
    assign rd_ok = r_en & ~empty;

    // Next-state logic for pointers, count and flags.
    always_comb begin
        wptr_d      = wptr;
        rptr_d      = rptr;
        count_d     = count;
        overflow_d  = overflow;
        underflow_d = underflow;
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) wptr_d = wptr + PTR_W'(1);
            if (rd_ok) rptr_d = rptr + PTR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count + PTR_W'(1);
                2'b01:   count_d = count - PTR_W'(1);
                default: count_d = count;
            endcase
            if (w_en && full)  overflow_d  = 1'b1;
            if (r_en && empty) underflow_d = 1'b1;
        end
        full_d         = (count_d == PTR_W'(DEPTH));
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= PTR_W'(AFULL_TH));
        almost_empty_d = (count_d <= PTR_W'(AEMPTY_TH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wptr         <= wptr_d;
            rptr         <= rptr_d;
            count        <= count_d;
            overflow     <= overflow_d;
            underflow    <= underflow_d;
            full         <= full_d;
            empty        <= empty_d;
            almost_full  <= almost_full_d;
            almost_empty <= almost_empty_d;
        end
    end

    // Storage array, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem[wptr[ADDR_W-1:0]] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem[rptr[ADDR_W-1:0]];
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_ok && !flush) begin
            rdata <= mem[rptr[ADDR_W-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (DATA_W=32, DEPTH=8, AFULL_TH=6, AEMPTY_TH=1).
// Stimulus pushes expected read words into a queue; a monitor pops and compares them.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        w_en;
    logic [31:0] wdata;
    logic        r_en;
    logic [31:0] rdata;
    logic        full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        overflow, underflow;

    sync_fifo_param #(.DATA_W(32), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .wdata(wdata),
        .r_en(r_en), .rdata(rdata), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];
    int          mcount = 0;
    logic        movf = 1'b0;
    logic        munf = 1'b0;
    logic        exp_rd = 1'b0;
    logic        fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == 8));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("almost_full", 32'(almost_full), 32'(mcount >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(mcount <= 1));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("underflow", 32'(underflow), 32'(munf));
    endtask

    task automatic model_reset();
        model_q.delete();
        mcount = 0;
        movf   = 1'b0;
        munf   = 1'b0;
    endtask

    // One clock of stimulus: drive at the falling edge, update model, check after the rising edge.
    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f);
        logic wok, rok;
        @(negedge clk);
        w_en = w; wdata = d; r_en = r; flush = f;
        if (f) begin
            exp_rd = 1'b0;
            model_reset();
        end else begin
            wok = w && (mcount < 8);
            rok = r && (mcount > 0);
            exp_rd = rok;
            if (rok) exp_q.push_back(model_q.pop_front());
            if (wok) model_q.push_back(d);
            mcount = mcount + int'(wok) - int'(rok);
            if (w && !wok) movf = 1'b1;
            if (r && !rok) munf = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_rd = 1'b0;
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
        check_status();
    endtask

    task automatic compare_read();
        if (exp_q.size() == 0) chk("sb_unexpected_read", 32'd1, 32'd0);
        else                   chk("rdata", rdata, exp_q.pop_front());
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented before the popping edge.
    always begin
        @(negedge clk);
        #1;
        if (exp_rd) compare_read();
    end
`else
    // Registered read: word appears just after the accepting edge.
    always begin
        @(posedge clk);
        fire = exp_rd;
        #1;
        if (fire) compare_read();
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_status();
`ifndef SYNC_FIFO_FWFT_EN
        chk("rdata_reset", rdata, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Fill with 0x11..0x88, then one rejected write.
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i * 32'h11), 1'b0, 1'b0);
        step(1'b1, 32'hDEAD, 1'b0, 1'b0);
        // Drain, then one rejected read.
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rdata_hold_underflow", rdata, 32'h88);
`endif
        step(1'b0, '0, 1'b0, 1'b1);

        // Steady state at count 4: two full pointer laps.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
        // Simultaneous access while full, then while empty.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hBAD0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h400, 1'b1, 1'b0);

        // Flush at count 5 with overflow set; the concurrent write is dropped.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hBEEF, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Async reset between edges at count 3.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_status();
`ifndef SYNC_FIFO_FWFT_EN
        chk("rdata_async_reset", rdata, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_status();

        // Read-mode check.
        step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_head", rdata, 32'hA5A5A5A5);
        chk("fwft_not_empty", 32'(empty), 32'd0);
`endif
        step(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("registered_read", rdata, 32'hA5A5A5A5);
`endif
        step(1'b0, '0, 1'b0, 1'b0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
